// File: rtl/a2d_spi_intf.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_spi_intf
//  Description : SPI master for an 8-channel 12-bit line-sensor A2D. A start
//                pulse runs two 16-bit transactions (command, then command
//                again while the result of the first is clocked back) and
//                presents the 12-bit result with a completion flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module a2d_spi_intf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX1  = 2'd1,
        GAP  = 2'd2,
        TX2  = 2'd3
    } state_t;

    // Divider value loaded when SS_n falls: SCLK stays high 9 clks first.
    localparam logic [4:0] c_div_porch = 5'b10111;
    // Divider value on the clk whose edge makes SCLK rise.
    localparam logic [4:0] c_div_rise  = 5'b01111;
    // Divider value on the clk whose edge shifts shreg (1 clk before SCLK falls).
    localparam logic [4:0] c_div_shift = 5'b11110;
    // The shift following this many samples closes a transaction.
    localparam logic [4:0] c_last_smpl = 5'd16;

    state_t      state_q,     state_d;
    logic [4:0]  sclk_div_q,  sclk_div_d;
    logic [15:0] shreg_q,     shreg_d;
    logic        miso_smpl_q, miso_smpl_d;
    logic [4:0]  smpl_cnt_q,  smpl_cnt_d;
    logic [2:0]  chnnl_q,     chnnl_d;
    logic        ss_n_q,      ss_n_d;
    logic        cnv_cmplt_q, cnv_cmplt_d;
    logic [11:0] res_q,       res_d;

    logic        w_busy;
    logic        w_sclk_rise;
    logic        w_shift;
    logic        w_last;
    logic [15:0] w_cmd;
    logic [15:0] w_shreg_shifted;

    assign w_busy          = (state_q == TX1) || (state_q == TX2);
    assign w_sclk_rise     = w_busy && (sclk_div_q == c_div_rise);
    assign w_shift         = w_busy && (sclk_div_q == c_div_shift) && (smpl_cnt_q != 5'd0);
    assign w_last          = w_shift && (smpl_cnt_q == c_last_smpl);
    assign w_cmd           = {2'b00, chnnl_q, 11'h000};
    assign w_shreg_shifted = {shreg_q[14:0], miso_smpl_q};

    assign cnv_cmplt = cnv_cmplt_q;
    assign res       = res_q;
    assign SS_n      = ss_n_q;
    assign SCLK      = w_busy ? sclk_div_q[4] : 1'b1;
    assign MOSI      = shreg_q[15];

    // Next-state decode for the sequencer and the SPI datapath.
    always_comb begin
        state_d     = state_q;
        sclk_div_d  = sclk_div_q;
        shreg_d     = shreg_q;
        miso_smpl_d = miso_smpl_q;
        smpl_cnt_d  = smpl_cnt_q;
        chnnl_d     = chnnl_q;
        ss_n_d      = ss_n_q;
        cnv_cmplt_d = cnv_cmplt_q;
        res_d       = res_q;

        if (w_busy) begin
            sclk_div_d = sclk_div_q + 5'd1;
        end
        if (w_sclk_rise) begin
            miso_smpl_d = MISO;
            smpl_cnt_d  = smpl_cnt_q + 5'd1;
        end
        if (w_shift) begin
            shreg_d = w_shreg_shifted;
        end

        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    chnnl_d     = chnnl;
                    shreg_d     = {2'b00, chnnl, 11'h000};
                    sclk_div_d  = c_div_porch;
                    smpl_cnt_d  = 5'd0;
                    ss_n_d      = 1'b0;
                    cnv_cmplt_d = 1'b0;
                    state_d     = TX1;
                end
            end
            TX1: begin
                // First reply is discarded; smpl_cnt times the 2-clk gap.
                if (w_last) begin
                    ss_n_d     = 1'b1;
                    smpl_cnt_d = 5'd0;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (smpl_cnt_q == 5'd1) begin
                    shreg_d    = w_cmd;
                    sclk_div_d = c_div_porch;
                    smpl_cnt_d = 5'd0;
                    ss_n_d     = 1'b0;
                    state_d    = TX2;
                end else begin
                    smpl_cnt_d = smpl_cnt_q + 5'd1;
                end
            end
            TX2: begin
                if (w_last) begin
                    ss_n_d      = 1'b1;
                    res_d       = w_shreg_shifted[11:0];
                    cnv_cmplt_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sclk_div_q  <= 5'd0;
            shreg_q     <= 16'h0000;
            miso_smpl_q <= 1'b0;
            smpl_cnt_q  <= 5'd0;
            chnnl_q     <= 3'd0;
            ss_n_q      <= 1'b1;
            cnv_cmplt_q <= 1'b0;
            res_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            sclk_div_q  <= sclk_div_d;
            shreg_q     <= shreg_d;
            miso_smpl_q <= miso_smpl_d;
            smpl_cnt_q  <= smpl_cnt_d;
            chnnl_q     <= chnnl_d;
            ss_n_q      <= ss_n_d;
            cnv_cmplt_q <= cnv_cmplt_d;
            res_q       <= res_d;
        end
    end

endmodule
`default_nettype wire
